// File: rtl/sync_debounce.sv
// Debounces a synchronized level: FILT_CYC consecutive samples qualify a change of filt_out and fire rise_pls/fall_pls.
// Build option SYNC_DEBOUNCE_EVT_CNT_EN adds a saturating qualified-edge counter with a sticky overflow flag.
module sync_debounce #(
  parameter int unsigned FILT_CYC = 16,
  parameter int unsigned FILT_W   = 8,
  parameter bit          INIT     = 1'b0,
  parameter int unsigned EDGE_SEL = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_sync,
  input  logic             evt_clr,
  output logic             filt_out,
  output logic             rise_pls,
  output logic             fall_pls,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             evt_ovf
);

  localparam logic [1:0] IDLE_LO = 2'd0;
  localparam logic [1:0] QUAL_HI = 2'd1;
  localparam logic [1:0] IDLE_HI = 2'd2;
  localparam logic [1:0] QUAL_LO = 2'd3;
  localparam logic [1:0] RST_ST  = INIT ? IDLE_HI : IDLE_LO;

  localparam logic [FILT_W-1:0] Q_ZERO   = {FILT_W{1'b0}};
  localparam logic [FILT_W-1:0] Q_ONE    = FILT_W'(1);
  localparam logic [FILT_W-1:0] FILT_LIM = FILT_W'(FILT_CYC);

  generate
    if (FILT_CYC == 0 || (FILT_CYC >> FILT_W) != 0) begin : g_bad_filt_cyc
      $error("sync_debounce: FILT_CYC must be in 1..2**FILT_W-1");
    end
  endgenerate

  logic [1:0]        state_r, state_s;
  logic [FILT_W-1:0] qcnt_r, qcnt_s, qinc_s;
  logic              filt_s, rise_s, fall_s;

  // Next-state logic; qcnt is zero in both IDLE states, so qinc_s==1 there and FILT_CYC=1 jumps IDLE->IDLE.
  always_comb begin
    state_s = state_r;
    qcnt_s  = qcnt_r;
    filt_s  = filt_out;
    rise_s  = 1'b0;
    fall_s  = 1'b0;
    qinc_s  = qcnt_r + Q_ONE;
    case (state_r)
      IDLE_LO, QUAL_HI: begin
        if (din_sync) begin
          if (qinc_s == FILT_LIM) begin
            state_s = IDLE_HI;
            qcnt_s  = Q_ZERO;
            filt_s  = 1'b1;
            rise_s  = 1'b1;
          end else begin
            state_s = QUAL_HI;
            qcnt_s  = qinc_s;
          end
        end else begin
          state_s = IDLE_LO;
          qcnt_s  = Q_ZERO;
        end
      end
      IDLE_HI, QUAL_LO: begin
        if (!din_sync) begin
          if (qinc_s == FILT_LIM) begin
            state_s = IDLE_LO;
            qcnt_s  = Q_ZERO;
            filt_s  = 1'b0;
            fall_s  = 1'b1;
          end else begin
            state_s = QUAL_LO;
            qcnt_s  = qinc_s;
          end
        end else begin
          state_s = IDLE_HI;
          qcnt_s  = Q_ZERO;
        end
      end
      default: begin
        state_s = RST_ST;
        qcnt_s  = Q_ZERO;
        filt_s  = INIT;
      end
    endcase
  end

  // Filter state and registered level/pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= RST_ST;
      qcnt_r   <= Q_ZERO;
      filt_out <= INIT;
      rise_pls <= 1'b0;
      fall_pls <= 1'b0;
    end else begin
      state_r  <= state_s;
      qcnt_r   <= qcnt_s;
      filt_out <= filt_s;
      rise_pls <= rise_s;
      fall_pls <= fall_s;
    end
  end

`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
  localparam logic [CNT_W-1:0] C_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic             evt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;

  // Event select: counts on the same edge that registers the matching pulse.
  always_comb begin
    evt_s = 1'b0;
    case (EDGE_SEL)
      32'd0:   evt_s = rise_s;
      32'd1:   evt_s = fall_s;
      32'd2:   evt_s = rise_s | fall_s;
      default: evt_s = 1'b0;
    endcase
  end

  // Saturating counter; a clear coincident with an event leaves a count of one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= C_ZERO;
      ovf_r <= 1'b0;
    end else if (evt_clr) begin
      cnt_r <= evt_s ? C_ONE : C_ZERO;
      ovf_r <= 1'b0;
    end else if (evt_s) begin
      if (&cnt_r) begin
        ovf_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + C_ONE;
      end
    end
  end

  assign evt_cnt = cnt_r;
  assign evt_ovf = ovf_r;
`else
  logic unused_evt_clr_s;
  assign unused_evt_clr_s = evt_clr;
  assign evt_cnt = {CNT_W{1'b0}};
  assign evt_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Randomized bench for sync_debounce: a FILT_CYC=16/CNT_W=4/EDGE_SEL=2 instance and a FILT_CYC=1 instance
// checked each cycle against a sample-history model, plus directed scenarios with literal expectations.
module tb_sync_debounce;

  localparam int FC16 = 16;
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, din16 = 1'b0, din1 = 1'b0, evt_clr = 1'b0;
  logic filt16, rise16, fall16, ovf16;
  logic [3:0] cnt16;
  logic filt1, rise1, fall1, ovf1;
  logic [15:0] cnt1;

  int n_cmp = 0, n_bad = 0;
  bit run_chk = 1'b0;

  // model state
  bit hist[$];
  bit e_filt16, e_rise16, e_fall16, e_ovf16;
  int e_cnt16;
  bit e_filt1, e_rise1, e_fall1, e_ovf1;
  int e_cnt1;

  sync_debounce #(.FILT_CYC(16), .FILT_W(8), .INIT(1'b0), .EDGE_SEL(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .din_sync(din16), .evt_clr(evt_clr),
    .filt_out(filt16), .rise_pls(rise16), .fall_pls(fall16), .evt_cnt(cnt16), .evt_ovf(ovf16)
  );

  sync_debounce #(.FILT_CYC(1), .FILT_W(8), .INIT(1'b0), .EDGE_SEL(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .din_sync(din1), .evt_clr(evt_clr),
    .filt_out(filt1), .rise_pls(rise1), .fall_pls(fall1), .evt_cnt(cnt1), .evt_ovf(ovf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void cnt_upd(input bit ev, input bit clr, input int max_v, inout int c, inout bit o);
    if (!CNT_EN) begin
      c = 0; o = 1'b0;
    end else if (clr) begin
      c = ev ? 1 : 0; o = 1'b0;
    end else if (ev) begin
      if (c == max_v) o = 1'b1;
      else c = c + 1;
    end
  endfunction

  task automatic model_reset();
    hist.delete();
    e_filt16 = 1'b0; e_rise16 = 1'b0; e_fall16 = 1'b0; e_cnt16 = 0; e_ovf16 = 1'b0;
    e_filt1 = 1'b0; e_rise1 = 1'b0; e_fall1 = 1'b0; e_cnt1 = 0; e_ovf1 = 1'b0;
  endtask

  // Output flips once the last FC16 samples since the previous flip all disagree with it.
  task automatic model_step(input bit d16, input bit d1, input bit clr);
    bit all_diff;
    hist.push_back(d16);
    if (hist.size() > FC16) void'(hist.pop_front());
    all_diff = (hist.size() == FC16);
    foreach (hist[i]) if (hist[i] == e_filt16) all_diff = 1'b0;
    e_rise16 = all_diff && !e_filt16;
    e_fall16 = all_diff && e_filt16;
    if (all_diff) begin
      e_filt16 = !e_filt16;
      hist.delete();
    end
    cnt_upd(e_rise16 | e_fall16, clr, 15, e_cnt16, e_ovf16);
    e_rise1 = d1 && !e_filt1;
    e_fall1 = !d1 && e_filt1;
    e_filt1 = d1;
    cnt_upd(e_rise1, clr, 65535, e_cnt1, e_ovf1);
  endtask

  task automatic step(input bit d16, input bit d1, input bit clr);
    din16 = d16; din1 = d1; evt_clr = clr;
    @(posedge clk);
    model_step(d16, d1, clr);
    #1;
  endtask

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    if (run_chk) begin
      chk("filt16", filt16, e_filt16);
      chk("rise16", rise16, e_rise16);
      chk("fall16", fall16, e_fall16);
      chk("cnt16", cnt16, e_cnt16);
      chk("ovf16", ovf16, e_ovf16);
      chk("filt1", filt1, e_filt1);
      chk("rise1", rise1, e_rise1);
      chk("fall1", fall1, e_fall1);
      chk("cnt1", cnt1, e_cnt1);
      chk("ovf1", ovf1, e_ovf1);
    end
  end

  initial begin
    int rises, falls, len;
    bit v;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run_chk = 1'b1;
    chk("rst_filt", filt16, 0);
    chk("rst_pls", {rise16, fall16}, 0);
    chk("rst_cnt", cnt16, 0);
    chk("rst_ovf", ovf16, 0);

    // clean step: rise on the 16th sample
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, rbit(), 1'b0);
      chk("step_rise", rise16, (i == 16));
      chk("step_filt", filt16, (i >= 16));
      chk("step_fall", fall16, 0);
    end
    for (int i = 1; i <= 16; i++) step(1'b0, rbit(), 1'b0);
    chk("fall_done", filt16, 0);

    // glitch rejection
    rises = 0; falls = 0;
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 15; i++) begin
        step(1'b1, rbit(), 1'b0);
        rises += rise16; falls += fall16;
      end
      step(1'b0, rbit(), 1'b0);
      rises += rise16; falls += fall16;
    end
    chk("glitch_rises", rises, 0);
    chk("glitch_falls", falls, 0);
    chk("glitch_filt", filt16, 0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, rbit(), 1'b0);
      rises += rise16;
    end
    chk("glitch_then_rise", rises, 1);

    // FILT_CYC=1 toggling
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    rises = 0; falls = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i % 2 == 0), 1'b0);
      chk("fc1_track", filt1, (i % 2 == 0));
      chk("fc1_excl", rise1 & fall1, 0);
      rises += rise1; falls += fall1;
    end
    chk("fc1_rises", rises, 4);
    chk("fc1_falls", falls, 4);

    // reset at qcnt=10
    for (int i = 0; i < 16; i++) step(1'b0, rbit(), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, rbit(), 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_filt", filt16, 0);
    chk("midrst_pls", {rise16, fall16}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, rbit(), 1'b0);
      chk("post_rst_rise", rise16, (i == 16));
    end

    // counter saturation, edges on both polarities
    step(1'b1, rbit(), 1'b1);
    chk("clr_cnt", cnt16, 0);
    for (int e = 1; e <= 17; e++) begin
      v = (e % 2 == 0);
      for (int j = 0; j < 16; j++) step(v, rbit(), (e == 17 && j == 15));
      if (e == 15) begin
        chk("sat15_cnt", cnt16, CNT_EN ? 15 : 0);
        chk("sat15_ovf", ovf16, 0);
      end else if (e == 16) begin
        chk("sat16_cnt", cnt16, CNT_EN ? 15 : 0);
        chk("sat16_ovf", ovf16, CNT_EN ? 1 : 0);
      end else if (e == 17) begin
        chk("clr17_cnt", cnt16, CNT_EN ? 1 : 0);
        chk("clr17_ovf", ovf16, 0);
        chk("clr17_fall", fall16, 1);
      end
    end

    // random runs
    for (int r = 0; r < 600; r++) begin
      v = rbit();
      len = $urandom_range(1, 24);
      for (int j = 0; j < len; j++) step(v, rbit(), ($urandom_range(0, 63) == 0));
    end

    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
